// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared types and helpers for the RV32M pipelined Vedic multiplier.
//   mul_op_e     : multiply mode encoding (MUL, MULH, MULHSU, MULHU)
//   op_a_signed  : 1 when operand a is treated as signed for the given mode
//   op_b_signed  : 1 when operand b is treated as signed for the given mode
//   MUL_LAT      : accept-to-result latency in cycles
// Configuration macro: VMUL_OUT_REG_EN (adds an output register, latency 4).
// -----------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

`ifdef VMUL_OUT_REG_EN
    localparam int MUL_LAT = 4;
`else
    localparam int MUL_LAT = 3;
`endif

    function automatic logic op_a_signed(input mul_op_e op);
        return op != MULHU;
    endfunction

    function automatic logic op_b_signed(input mul_op_e op);
        return (op == MUL) || (op == MULH);
    endfunction

endpackage

// File: rtl/vedic_mul_core.sv
// -----------------------------------------------------------------------------
// vedic_mul_core
// Purely combinational unsigned W x W -> 2W multiplier using the Urdhva
// Tiryagbhyam (vertically and crosswise) method: each product column k sums
// every a[i]&b[k-i] cross term plus the carry rippling in from column k-1.
// Ports:
//   i_a, i_b : W-bit unsigned operands
//   o_p      : 2W-bit unsigned product
// -----------------------------------------------------------------------------
module vedic_mul_core #(
    parameter int W = 16
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_p
);

    // A column holds at most W cross terms plus a carry below W, so it stays
    // under 2W and CW bits are always enough.
    localparam int CW = $clog2(W) + 2;

    logic [CW-1:0] w_col;
    logic [CW-1:0] w_carry;

    always_comb begin
        // NOTE: every variable gets a default before the loops so no path
        // leaves a value unassigned and no latch is inferred.
        o_p     = '0;
        w_col   = '0;
        w_carry = '0;
        for (int k = 0; k < 2 * W; k++) begin
            int lo;
            int hi;
            lo    = (k < W) ? 0 : k - W + 1;
            hi    = (k < W) ? k : W - 1;
            w_col = w_carry;
            for (int i = lo; i <= hi; i++) begin
                w_col = w_col + CW'(i_a[i] & i_b[k - i]);
            end
            o_p[k]  = w_col[0];
            w_carry = w_col >> 1;
        end
    end

endmodule

// File: rtl/vedic_mul_pipe.sv
// -----------------------------------------------------------------------------
// vedic_mul_pipe
// Pipelined WIDTH x WIDTH multiplier for the RV32M execute stage supporting
// MUL, MULH, MULHSU and MULHU, with valid/ready handshakes and a pass-through tag.
//   S1: operand sign conditioning (magnitudes + product sign)
//   S2: four (WIDTH/2)^2 partial products from vedic_mul_core
//   S3: accumulation, sign fix, output half select
//   S4: optional output register (VMUL_OUT_REG_EN defined), latency 4 instead of 3
// Ports:
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   in_valid_i / in_ready_o  : input handshake (in_ready_o = ~stall)
//   op_i, a_i, b_i, tag_i    : mode, rs1, rs2, sideband tag
//   flush_i                  : drop every in-flight op, including one accepted now
//   out_valid_o / out_ready_i: output handshake, outputs held while stalled
//   result_o, tag_o          : selected product half and its tag
// -----------------------------------------------------------------------------
module vedic_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int H = WIDTH / 2;

    // ---------------- handshake ----------------
    logic w_stall;
    logic w_accept;

    // A stalled output freezes the whole pipe, so bubbles never overtake data.
    assign w_stall    = out_valid_o & ~out_ready_i;
    assign in_ready_o = ~w_stall;
    assign w_accept   = in_valid_i & in_ready_o;

    // ---------------- S1: sign conditioning ----------------
    mul_op_e          w_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_op    = mul_op_e'(op_i);
    assign w_a_neg = op_a_signed(w_op) & a_i[WIDTH-1];
    assign w_b_neg = op_b_signed(w_op) & b_i[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which read as unsigned is the right magnitude.
    assign w_mag_a = w_a_neg ? -a_i : a_i;
    assign w_mag_b = w_b_neg ? -b_i : b_i;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_neg;
    logic             r_s1_hi;
    logic [TAG_W-1:0] r_s1_tag;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)       r_s1_valid <= 1'b0;
        else if (flush_i)  r_s1_valid <= 1'b0;
        else if (!w_stall) r_s1_valid <= w_accept;
    end

    // NOTE: datapath registers are not reset; only the valid bits qualify them,
    // and loads are gated by upstream valid to avoid needless toggling.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_s1_a   <= w_mag_a;
            r_s1_b   <= w_mag_b;
            r_s1_neg <= w_a_neg ^ w_b_neg;
            r_s1_hi  <= (w_op != MUL);
            r_s1_tag <= tag_i;
        end
    end

    // ---------------- S2: partial products ----------------
    logic [WIDTH-1:0] w_pp_ll;
    logic [WIDTH-1:0] w_pp_lh;
    logic [WIDTH-1:0] w_pp_hl;
    logic [WIDTH-1:0] w_pp_hh;

    vedic_mul_core #(.W(H)) u_core_ll (.i_a(r_s1_a[H-1:0]),     .i_b(r_s1_b[H-1:0]),     .o_p(w_pp_ll));
    vedic_mul_core #(.W(H)) u_core_lh (.i_a(r_s1_a[H-1:0]),     .i_b(r_s1_b[WIDTH-1:H]), .o_p(w_pp_lh));
    vedic_mul_core #(.W(H)) u_core_hl (.i_a(r_s1_a[WIDTH-1:H]), .i_b(r_s1_b[H-1:0]),     .o_p(w_pp_hl));
    vedic_mul_core #(.W(H)) u_core_hh (.i_a(r_s1_a[WIDTH-1:H]), .i_b(r_s1_b[WIDTH-1:H]), .o_p(w_pp_hh));

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_ll;
    logic [WIDTH-1:0] r_s2_lh;
    logic [WIDTH-1:0] r_s2_hl;
    logic [WIDTH-1:0] r_s2_hh;
    logic             r_s2_neg;
    logic             r_s2_hi;
    logic [TAG_W-1:0] r_s2_tag;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)       r_s2_valid <= 1'b0;
        else if (flush_i)  r_s2_valid <= 1'b0;
        else if (!w_stall) r_s2_valid <= r_s1_valid;
    end

    always_ff @(posedge clk_i) begin
        if (!w_stall && r_s1_valid) begin
            r_s2_ll  <= w_pp_ll;
            r_s2_lh  <= w_pp_lh;
            r_s2_hl  <= w_pp_hl;
            r_s2_hh  <= w_pp_hh;
            r_s2_neg <= r_s1_neg;
            r_s2_hi  <= r_s1_hi;
            r_s2_tag <= r_s1_tag;
        end
    end

    // ---------------- S3: accumulate, sign fix, half select ----------------
    logic [2*WIDTH-1:0] w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_sel;

    // hh and ll do not overlap, so they concatenate; the cross terms sit at H.
    assign w_sum  = {r_s2_hh, r_s2_ll}
                  + {{H{1'b0}}, r_s2_lh, {H{1'b0}}}
                  + {{H{1'b0}}, r_s2_hl, {H{1'b0}}};
    // Negating a zero product gives zero again, so no negative-zero case exists.
    assign w_prod = r_s2_neg ? -w_sum : w_sum;
    assign w_sel  = r_s2_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];

    logic             r_s3_valid;
    logic [WIDTH-1:0] r_s3_result;
    logic [TAG_W-1:0] r_s3_tag;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s3_valid  <= 1'b0;
            r_s3_result <= '0;
            r_s3_tag    <= '0;
        end else begin
            if (flush_i)       r_s3_valid <= 1'b0;
            else if (!w_stall) r_s3_valid <= r_s2_valid;
            if (!w_stall && r_s2_valid) begin
                r_s3_result <= w_sel;
                r_s3_tag    <= r_s2_tag;
            end
        end
    end

`ifdef VMUL_OUT_REG_EN
    // ---------------- S4: output register ----------------
    logic             r_s4_valid;
    logic [WIDTH-1:0] r_s4_result;
    logic [TAG_W-1:0] r_s4_tag;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_s4_valid  <= 1'b0;
            r_s4_result <= '0;
            r_s4_tag    <= '0;
        end else begin
            if (flush_i)       r_s4_valid <= 1'b0;
            else if (!w_stall) r_s4_valid <= r_s3_valid;
            if (!w_stall && r_s3_valid) begin
                r_s4_result <= r_s3_result;
                r_s4_tag    <= r_s3_tag;
            end
        end
    end

    assign out_valid_o = r_s4_valid;
    assign result_o    = r_s4_result;
    assign tag_o       = r_s4_tag;
`else
    assign out_valid_o = r_s3_valid;
    assign result_o    = r_s3_result;
    assign tag_o       = r_s3_tag;
`endif

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_vedic_mul_pipe
// Self-checking bench for vedic_mul_pipe (WIDTH=32, TAG_W=5). Expected results
// come from wide signed arithmetic on sign/zero-extended operands; a queue
// scoreboard tracks accepted ops, dropping them on flush or reset.
// Honours VMUL_OUT_REG_EN for the expected latency.
// -----------------------------------------------------------------------------
module tb_vedic_mul_pipe;

`ifdef VMUL_OUT_REG_EN
    localparam int LAT_EXP = 4;
`else
    localparam int LAT_EXP = 3;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    logic        hold_prev = 1'b0;
    logic [31:0] prev_result;
    logic [4:0]  prev_tag;

    always #5 clk = ~clk;

    vedic_mul_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .tag_i      (tag_in),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o   (result),
        .tag_o      (tag_out)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, obs, exp);
        end
    endtask

    // Reference: extend each operand to 33 bits by its signedness, multiply exactly.
    function automatic logic [31:0] ref_mul(input logic [1:0] f_op, input logic [31:0] f_a,
                                            input logic [31:0] f_b);
        logic signed [32:0] ea;
        logic signed [32:0] eb;
        logic signed [65:0] p;
        ea = (f_op != 2'b11)  ? {f_a[31], f_a} : {1'b0, f_a};
        eb = (f_op[1] == 1'b0) ? {f_b[31], f_b} : {1'b0, f_b};
        p  = ea * eb;
        return (f_op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor; samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid",  32'(out_valid), 32'd1);
                check("hold_result", result, prev_result);
                check("hold_tag",    32'(tag_out), 32'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("tag",    32'(tag_out), 32'(e.tag));
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back('{ref_mul(op, a, b), tag_in});
            hold_prev   = out_valid && !out_ready && !flush;
            prev_result = result;
            prev_tag    = tag_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d_op, input logic [31:0] d_a,
                         input logic [31:0] d_b, input logic [4:0] d_t);
        in_valid = v;
        op       = d_op;
        a        = d_a;
        b        = d_b;
        tag_in   = d_t;
    endtask

    task automatic drive_random();
        drive(1'b1, 2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 5'($urandom));
    endtask

    // Single op in an empty pipe: checks accept, latency, value and tag.
    task automatic run_one(input string name, input logic [1:0] r_op, input logic [31:0] r_a,
                           input logic [31:0] r_b, input logic [4:0] r_t, input logic [31:0] r_exp);
        int lat;
        lat = 0;
        step();
        drive(1'b1, r_op, r_a, r_b, r_t);
        @(negedge clk);
        check({name, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check({name, "_lat"}, 32'(lat), 32'(LAT_EXP));
        check({name, "_val"}, result, r_exp);
        check({name, "_tag"}, 32'(tag_out), 32'(r_t));
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int sent;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_tag",    32'(tag_out), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Directed operand corners
        run_one("mul_neg",   2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB);
        run_one("mulh_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000);
        run_one("mul_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h0000_0000);
        run_one("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFF);
        run_one("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE);
        run_one("mulh_zero", 2'b01, 32'h0000_0000, 32'h8000_0001, 5'd6,  32'h0000_0000);
        drain();

        // Back-to-back stream of 8 with out_ready low in cycles 4-6
        sent = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            out_ready = !(c >= 4 && c <= 6);
            if (sent < 8) drive_random();
            else          in_valid = 1'b0;
            @(negedge clk);
            if (c <= 12) check("stall_ready", 32'(in_ready), 32'(!(c >= 4 && c <= 6)));
            if (in_valid && in_ready) sent++;
            if (sent == 8 && c > 12) break;
        end
        drain();

        // Flush with a full pipe plus one accepted in the flush cycle
        for (int c = 0; c < LAT_EXP - 1; c++) begin
            step();
            drive_random();
        end
        step();
        drive_random();
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(in_ready), 32'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < LAT_EXP + 2; c++) begin
            @(negedge clk);
            check("flush_quiet", 32'(out_valid), 32'd0);
        end
        run_one("post_flush", 2'b11, 32'h1234_5678, 32'h0000_0010, 5'd12, 32'h0000_0001);
        drain();

        // Reset during traffic
        for (int c = 0; c < 5; c++) begin
            step();
            drive_random();
        end
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check("midrst_valid",  32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        step();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < LAT_EXP + 2; c++) begin
            @(negedge clk);
            check("midrst_ready", 32'(in_ready), 32'd1);
            check("midrst_quiet", 32'(out_valid), 32'd0);
        end

        // Randomised traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) drive_random();
            else                           in_valid = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
